// File: rtl/change_dispenser.sv
// Greedy change payout: latches the balance on a return-request edge and issues one coin per handshake.
// Optional per-denomination stock tracking is compiled in with `define CHANGE_STOCK_EN.
module change_dispenser #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
    parameter int STOCK_INIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [TOTAL_BITS-1:0] i_balance,
    input  logic                  i_coin_ready,
`ifdef CHANGE_STOCK_EN
    input  logic [NUM_COINS-1:0]  i_refill,
    output logic [NUM_COINS-1:0]  o_stock_empty,
`endif
    output logic                  o_coin_valid,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_short,
    output logic [TOTAL_BITS-1:0] o_remaining
);

    localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    state_t             state;
    logic               req_q;
    logic [IDX_W-1:0]   coin_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [NUM_COINS-1:0] avail;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
        case (k)
            0:       coin_value = TOTAL_BITS'(COIN_VAL0);
            1:       coin_value = TOTAL_BITS'(COIN_VAL1);
            default: coin_value = TOTAL_BITS'(COIN_VAL2);
        endcase
    endfunction

`ifdef CHANGE_STOCK_EN
    logic [7:0] stock [NUM_COINS];
    logic       accept;

    assign accept = (state == ISSUE) && i_coin_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_COINS; k++) stock[k] <= 8'(STOCK_INIT);
        end else begin
            // Simultaneous refill and dispense on one coin cancel out.
            for (int k = 0; k < NUM_COINS; k++) begin
                if (accept && coin_idx == IDX_W'(k) && !i_refill[k])
                    stock[k] <= stock[k] - 8'd1;
                else if (i_refill[k] && !(accept && coin_idx == IDX_W'(k)) && stock[k] != 8'hff)
                    stock[k] <= stock[k] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_COINS; k++) o_stock_empty[k] = (stock[k] == 8'd0);
    end

    assign avail = ~o_stock_empty;
`else
    assign avail = '1;
`endif

    // Ascending scan: the last qualifying index wins, giving the largest payable coin.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (avail[k] && coin_value(k) <= o_remaining) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end

    assign o_busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_q         <= 1'b0;
            coin_idx      <= '0;
            o_coin_valid  <= 1'b0;
            o_return_coin <= '0;
            o_done        <= 1'b0;
            o_short       <= 1'b0;
            o_remaining   <= '0;
        end else begin
            req_q  <= i_return_req;
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_return_req && !req_q) begin
                        o_remaining <= i_balance;
                        o_short     <= 1'b0;
                        state       <= (i_balance == '0) ? DONE : SELECT;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        coin_idx      <= sel_idx;
                        o_coin_valid  <= 1'b1;
                        o_return_coin <= NUM_COINS'(1) << sel_idx;
                        state         <= ISSUE;
                    end else begin
                        state <= DONE;
                    end
                end
                ISSUE: begin
                    if (i_coin_ready) begin
                        o_remaining   <= o_remaining - coin_value(int'(coin_idx));
                        o_coin_valid  <= 1'b0;
                        o_return_coin <= '0;
                        state         <= SELECT;
                    end
                end
                DONE: begin
                    o_done  <= 1'b1;
                    o_short <= (o_remaining != '0);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins are queued at trigger time and popped on each handshake.
// Build with CHANGE_STOCK_EN defined to exercise the stock-limited scenario instead of the default ones.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_return_req;
    logic [30:0] i_balance;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic        o_short;
    logic [30:0] o_remaining;
`ifdef CHANGE_STOCK_EN
    logic [2:0]  i_refill;
    logic [2:0]  o_stock_empty;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];

    change_dispenser #(
`ifdef CHANGE_STOCK_EN
        .STOCK_INIT(1)
`else
        .STOCK_INIT(8)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_return_req (i_return_req),
        .i_balance    (i_balance),
        .i_coin_ready (i_coin_ready),
`ifdef CHANGE_STOCK_EN
        .i_refill     (i_refill),
        .o_stock_empty(o_stock_empty),
`endif
        .o_coin_valid (o_coin_valid),
        .o_return_coin(o_return_coin),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_short      (o_short),
        .o_remaining  (o_remaining)
    );

    always #5 clk = ~clk;

    // Every accepted coin is compared against the head of the expectation queue.
    always @(negedge clk) begin
        if (reset_n && o_coin_valid && i_coin_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL coin_unexpected: got %b, required no coin", o_return_coin);
            end else begin
                logic [2:0] exp_coin;
                exp_coin = exp_q.pop_front();
                if (o_return_coin !== exp_coin) begin
                    miscompares++;
                    $display("FAIL coin_order: got %b, required %b", o_return_coin, exp_coin);
                end
            end
        end
    end

    // Forces a clean 0->1 request edge; returns just after the edge that samples the trigger.
    task automatic trigger(input logic [30:0] bal);
        @(posedge clk); #1 i_return_req = 1'b0;
        @(posedge clk); #1 i_balance = bal; i_return_req = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d coins still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if ({o_coin_valid, o_return_coin, o_busy, o_done, o_short, o_remaining} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b c=%b b=%b d=%b s=%b r=%0d, required all 0",
                     o_coin_valid, o_return_coin, o_busy, o_done, o_short, o_remaining);
        end
        #9 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({o_coin_valid, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got v=%b b=%b d=%b, required 000", o_coin_valid, o_busy, o_done);
        end
    endtask

`ifndef CHANGE_STOCK_EN
    task automatic test_greedy;
        bit got;
        i_coin_ready = 1'b1;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        trigger(31'd1600);
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1 || o_coin_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL greedy_select: got busy=%b valid=%b, required busy=1 valid=0", o_busy, o_coin_valid);
        end
        @(negedge clk);
        vectors++;
        if (o_coin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL greedy_latency: got valid=%b, required 1", o_coin_valid);
        end
        wait_done(40, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL greedy_timeout: got no done within 40 cycles, required done");
        end
        vectors++;
        if (o_remaining !== 31'd0 || o_short !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL greedy_final: got rem=%0d short=%b busy=%b, required 0 0 0", o_remaining, o_short, o_busy);
        end
        check_drained("greedy");
    endtask

    task automatic test_stall;
        bit got;
        i_coin_ready = 1'b0;
        exp_q.push_back(3'b010);
        trigger(31'd500);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (o_coin_valid !== 1'b1 || o_return_coin !== 3'b010 || o_remaining !== 31'd500) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b c=%b rem=%0d, required 1 010 500",
                         i, o_coin_valid, o_return_coin, o_remaining);
            end
        end
        @(posedge clk); #1 i_coin_ready = 1'b1;
        wait_done(20, got);
        vectors++;
        if (!got || o_remaining !== 31'd0 || o_short !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_final: got done=%b rem=%0d short=%b, required 1 0 0", got, o_remaining, o_short);
        end
        check_drained("stall");
    endtask

    task automatic test_zero;
        i_coin_ready = 1'b1;
        trigger(31'd0);
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_coin_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_donestate: got busy=%b done=%b valid=%b, required 1 0 0", o_busy, o_done, o_coin_valid);
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b1 || o_short !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b short=%b busy=%b, required 1 0 0", o_done, o_short, o_busy);
        end
    endtask

    task automatic test_short_no_retrigger;
        bit got;
        int busy_cycles;
        i_coin_ready = 1'b1;
        exp_q.push_back(3'b001);
        trigger(31'd150);
        wait_done(20, got);
        vectors++;
        if (!got || o_remaining !== 31'd50 || o_short !== 1'b1) begin
            miscompares++;
            $display("FAIL short_final: got done=%b rem=%0d short=%b, required 1 50 1", got, o_remaining, o_short);
        end
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_busy) busy_cycles++;
        end
        vectors++;
        if (busy_cycles != 0 || o_short !== 1'b1 || o_remaining !== 31'd50) begin
            miscompares++;
            $display("FAIL short_retrigger: got busy_cycles=%0d short=%b rem=%0d, required 0 1 50",
                     busy_cycles, o_short, o_remaining);
        end
        check_drained("short");
    endtask

    task automatic test_reset_mid_payout;
        bit got;
        i_coin_ready = 1'b0;
        trigger(31'd1500);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = o_coin_valid;
        end
        vectors++;
        if (!got || o_return_coin !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_issue: got valid=%b coin=%b, required 1 100", got, o_return_coin);
        end
        #2 reset_n = 1'b0;
        i_return_req = 1'b0;
        #1;
        vectors++;
        if ({o_coin_valid, o_return_coin, o_busy, o_done, o_short, o_remaining} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got v=%b c=%b b=%b d=%b s=%b r=%0d, required all 0",
                     o_coin_valid, o_return_coin, o_busy, o_done, o_short, o_remaining);
        end
        #1 reset_n = 1'b1;
        i_coin_ready = 1'b1;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        trigger(31'd600);
        i_balance = 31'd9999;
        wait_done(30, got);
        vectors++;
        if (!got || o_remaining !== 31'd0 || o_short !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_restart: got done=%b rem=%0d short=%b, required 1 0 0", got, o_remaining, o_short);
        end
        check_drained("abort");
    endtask
`else
    task automatic test_stock_limit;
        bit got;
        vectors++;
        if (o_stock_empty !== 3'b000) begin
            miscompares++;
            $display("FAIL stock_init: got empty=%b, required 000", o_stock_empty);
        end
        i_coin_ready = 1'b1;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        trigger(31'd2000);
        wait_done(40, got);
        vectors++;
        if (!got || o_remaining !== 31'd400 || o_short !== 1'b1) begin
            miscompares++;
            $display("FAIL stock_final: got done=%b rem=%0d short=%b, required 1 400 1", got, o_remaining, o_short);
        end
        vectors++;
        if (o_stock_empty !== 3'b111) begin
            miscompares++;
            $display("FAIL stock_empty: got %b, required 111", o_stock_empty);
        end
        @(posedge clk); #1 i_refill = 3'b001;
        @(posedge clk); #1 i_refill = 3'b000;
        @(negedge clk);
        vectors++;
        if (o_stock_empty !== 3'b110) begin
            miscompares++;
            $display("FAIL stock_refill: got %b, required 110", o_stock_empty);
        end
        check_drained("stock");
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        i_return_req = 1'b0;
        i_balance    = '0;
        i_coin_ready = 1'b0;
`ifdef CHANGE_STOCK_EN
        i_refill     = '0;
`endif
        test_reset();
`ifdef CHANGE_STOCK_EN
        test_stock_limit();
`else
        test_greedy();
        test_stall();
        test_zero();
        test_short_no_retrigger();
        test_reset_mid_payout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Return-side counterpart of the vending machine's coin-intake and timeout path. When the timeout/return flag rises, it latches the current balance and pays it out one coin per handshake, largest denomination first (greedy). It reports completion and any residual it could not pay. It sits between the vending-machine balance logic and the physical coin-out interface.

Parameters:
NUM_COINS, 3, number of coin denominations (index 0 = smallest)
TOTAL_BITS, 31, width of balance/remaining arithmetic
COIN_VAL0, 100, value of coin index 0
COIN_VAL1, 500, value of coin index 1
COIN_VAL2, 1000, value of coin index 2
STOCK_INIT, 8, initial per-denomination stock (used only with CHANGE_STOCK_EN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_return_req  input  1  return request (level, e.g. timeout return flag); rising edge triggers payout
i_balance  input  TOTAL_BITS  balance to return; sampled on the trigger cycle only
i_coin_ready  input  1  coin-out mechanism accepts the presented coin this cycle
o_coin_valid  output  1  a coin is being presented
o_return_coin  output  NUM_COINS  one-hot denomination presented; 0 when not valid
o_busy  output  1  payout in progress (state != IDLE)
o_done  output  1  one-cycle pulse at end of payout
o_short  output  1  with o_done: residual nonzero; holds until next trigger
o_remaining  output  TOTAL_BITS  unpaid amount; live during payout, final value held after done

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; internal request-edge register 0; remaining 0.
- Trigger: rising edge of i_return_req (registered previous value 0, current 1) while in IDLE. Edges while not in IDLE are ignored. A level held high after done does not retrigger.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE: on trigger, remaining <= i_balance, o_short <= 0, go to SELECT. If i_balance==0, go straight to DONE.
- SELECT (1 cycle, outputs not valid): pick the highest index k with COIN_VALk <= remaining (and stock_k>0 if the feature is enabled). If found, latch k and go to ISSUE. If none, go to DONE.
- ISSUE: o_coin_valid=1 and o_return_coin=onehot(k), both stable until accepted. When i_coin_ready=1 at the clock edge: remaining <= remaining - COIN_VALk, go to SELECT. If not ready, stay; remaining is unchanged.
- DONE: o_done=1 for exactly one cycle; o_short <= (remaining != 0); go to IDLE.
- Latency: trigger edge at cycle N gives first o_coin_valid in cycle N+2. Each accepted coin adds 2 cycles (ISSUE then SELECT).
- Arithmetic: unsigned, TOTAL_BITS wide. Subtraction never underflows because the selection guarantees value <= remaining.
- o_busy = (state != IDLE), including the DONE cycle.
- i_balance changes after the trigger have no effect.
- Reset mid-payout: immediate abort, outputs 0, no done pulse.

Optional Feature:
Macro CHANGE_STOCK_EN.
- Enabled:
  - Per-denomination 8-bit stock counters, reset to STOCK_INIT.
  - An accepted coin decrements its stock.
  - Extra input i_refill [NUM_COINS] (one-hot pulse) adds 1, saturating at 255. A refill and a dispense on the same coin in the same cycle leave the count unchanged.
  - Extra output o_stock_empty [NUM_COINS] gives stock==0 per coin.
  - SELECT skips denominations with zero stock.
- Disabled: stock is unlimited; no extra ports.

Test Plan:
1. i_balance=1600, trigger, i_coin_ready=1 -> coins 1000, 500, 100 on successive ISSUE cycles; o_done pulse; o_remaining=0; o_short=0.
2. i_balance=500, i_coin_ready low for 3 cycles then high -> o_return_coin=3'b010 and valid held 3 cycles; o_remaining stays 500 then becomes 0.
3. i_balance=0, trigger -> no o_coin_valid; o_done pulse 2 cycles after the trigger edge (IDLE->DONE); o_short=0.
4. i_balance=150 -> one coin 100; done with o_remaining=50, o_short=1; i_return_req held high afterward -> no second payout.
5. reset_n pulsed low during ISSUE of balance 1500 -> outputs 0 asynchronously; IDLE; a new trigger restarts from the new i_balance.
6. CHANGE_STOCK_EN, STOCK_INIT=1, i_balance=2000 -> coins 1000, 500, 100; o_remaining=400, o_short=1; o_stock_empty=3'b111.
